// File: rtl/ps2_move_decoder.sv
// PS/2 scan-code front end for the chess board: assembles square entries
// and command keys into single ready/valid writes to the board registers.
module ps2_move_decoder #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int NUM_SLOTS  = 2,
    parameter int BASE_ADDR  = 64,
    parameter int CMD_R_ADDR = 67,
    parameter int CMD_K_ADDR = 68,
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        ps2_key_data,
    input  logic              ps2_key_pressed,
    input  logic              keyboard_write_ready,
    output logic              keyboard_we,
    output logic [ADDR_W-1:0] keyboard_write_address,
    output logic [DATA_W-1:0] keyboard_write_data,
    output logic [SLOT_W-1:0] current_slot,
    output logic [7:0]        drop_count
);

    typedef enum logic {COLLECT, WRITE} state_t;

    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_SLOTS - 1);

    state_t            state, n_state;
    logic              n_we;
    logic [ADDR_W-1:0] n_addr;
    logic [DATA_W-1:0] n_data;
    logic [SLOT_W-1:0] n_slot;
    logic [7:0]        n_drop;
    logic              let_v, n_let_v, num_v, n_num_v;
    logic [2:0]        let_i, n_let_i, num_i, n_num_i;
    logic              brk, n_brk, ext, n_ext;
    logic [3:0]        let_dec, num_dec;

    // {valid, index} for the file letters a..h
    function automatic logic [3:0] dec_letter(input logic [7:0] b);
        case (b)
            8'h1C:   dec_letter = 4'b1_000;
            8'h32:   dec_letter = 4'b1_001;
            8'h21:   dec_letter = 4'b1_010;
            8'h23:   dec_letter = 4'b1_011;
            8'h24:   dec_letter = 4'b1_100;
            8'h2B:   dec_letter = 4'b1_101;
            8'h34:   dec_letter = 4'b1_110;
            8'h33:   dec_letter = 4'b1_111;
            default: dec_letter = 4'b0_000;
        endcase
    endfunction

    // {valid, index} for the rank digits 1..8
    function automatic logic [3:0] dec_number(input logic [7:0] b);
        case (b)
            8'h16:   dec_number = 4'b1_000;
            8'h1E:   dec_number = 4'b1_001;
            8'h26:   dec_number = 4'b1_010;
            8'h25:   dec_number = 4'b1_011;
            8'h2E:   dec_number = 4'b1_100;
            8'h36:   dec_number = 4'b1_101;
            8'h3D:   dec_number = 4'b1_110;
            8'h3E:   dec_number = 4'b1_111;
            default: dec_number = 4'b0_000;
        endcase
    endfunction

    assign let_dec = dec_letter(ps2_key_data);
    assign num_dec = dec_number(ps2_key_data);

    always_comb begin
        n_state = state;
        n_we    = keyboard_we;
        n_addr  = keyboard_write_address;
        n_data  = keyboard_write_data;
        n_slot  = current_slot;
        n_drop  = drop_count;
        n_let_v = let_v;
        n_let_i = let_i;
        n_num_v = num_v;
        n_num_i = num_i;
        n_brk   = brk;
        n_ext   = ext;

        if (state == WRITE && keyboard_write_ready) begin
            n_state = COLLECT;
            n_we    = 1'b0;
        end

        if (ps2_key_pressed) begin
            if (ps2_key_data == 8'hF0) begin
                n_brk = 1'b1;
            end else if (ps2_key_data == 8'hE0) begin
                n_ext = 1'b1;
            end else if (brk) begin
                n_brk = 1'b0;
                n_ext = 1'b0;
            end else if (state == WRITE) begin
                n_ext = 1'b0;
                if (drop_count != 8'hFF)
                    n_drop = drop_count + 8'd1;
            end else if (ext) begin
                n_ext = 1'b0;
                if (ps2_key_data == 8'h6B || ps2_key_data == 8'h74) begin
                    n_let_v = 1'b0;
                    n_num_v = 1'b0;
                    if (ps2_key_data == 8'h6B && current_slot != '0)
                        n_slot = current_slot - SLOT_W'(1);
                    if (ps2_key_data == 8'h74 && current_slot < SLOT_MAX)
                        n_slot = current_slot + SLOT_W'(1);
                end
            end else if (let_dec[3]) begin
                n_let_v = 1'b1;
                n_let_i = let_dec[2:0];
            end else if (num_dec[3]) begin
                n_num_v = 1'b1;
                n_num_i = num_dec[2:0];
            end else if (ps2_key_data == 8'h66) begin
                n_let_v = 1'b0;
                n_num_v = 1'b0;
            end else if (ps2_key_data == 8'h2D || ps2_key_data == 8'h42) begin
                n_let_v = 1'b0;
                n_num_v = 1'b0;
                n_state = WRITE;
                n_we    = 1'b1;
                n_data  = DATA_W'(1);
                n_addr  = (ps2_key_data == 8'h2D) ? ADDR_W'(CMD_R_ADDR)
                                                  : ADDR_W'(CMD_K_ADDR);
            end
        end

        // a square completes on the edge both halves become valid
        if (state == COLLECT && n_let_v && n_num_v) begin
            n_state = WRITE;
            n_we    = 1'b1;
            n_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(current_slot);
            n_data  = DATA_W'({n_num_i, n_let_i});
            n_let_v = 1'b0;
            n_num_v = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= COLLECT;
            keyboard_we            <= 1'b0;
            keyboard_write_address <= ADDR_W'(BASE_ADDR);
            keyboard_write_data    <= '0;
            current_slot           <= '0;
            drop_count             <= '0;
            let_v                  <= 1'b0;
            let_i                  <= '0;
            num_v                  <= 1'b0;
            num_i                  <= '0;
            brk                    <= 1'b0;
            ext                    <= 1'b0;
        end else begin
            state                  <= n_state;
            keyboard_we            <= n_we;
            keyboard_write_address <= n_addr;
            keyboard_write_data    <= n_data;
            current_slot           <= n_slot;
            drop_count             <= n_drop;
            let_v                  <= n_let_v;
            let_i                  <= n_let_i;
            num_v                  <= n_num_v;
            num_i                  <= n_num_i;
            brk                    <= n_brk;
            ext                    <= n_ext;
        end
    end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed table-driven bench for ps2_move_decoder.
module tb_ps2_move_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  ps2_key_data;
    logic        ps2_key_pressed;
    logic        keyboard_write_ready;
    logic        keyboard_we;
    logic [11:0] keyboard_write_address;
    logic [31:0] keyboard_write_data;
    logic [0:0]  current_slot;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        pr;
        logic [7:0]  kd;
        logic        rdy;
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic [0:0]  slot;
        logic [7:0]  drop;
    } vec_t;

    vec_t vq[$];

    ps2_move_decoder dut (
        .clock                  (clock),
        .reset                  (reset),
        .ps2_key_data           (ps2_key_data),
        .ps2_key_pressed        (ps2_key_pressed),
        .keyboard_write_ready   (keyboard_write_ready),
        .keyboard_we            (keyboard_we),
        .keyboard_write_address (keyboard_write_address),
        .keyboard_write_data    (keyboard_write_data),
        .current_slot           (current_slot),
        .drop_count             (drop_count)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic pr, input logic [7:0] kd,
                                input logic rdy, input logic we,
                                input logic [11:0] addr, input logic [31:0] data,
                                input logic [0:0] slot, input logic [7:0] drop);
        vec_t v;
        v.pr = pr; v.kd = kd; v.rdy = rdy; v.we = we;
        v.addr = addr; v.data = data; v.slot = slot; v.drop = drop;
        return v;
    endfunction

    task automatic check(input string name, input logic we, input logic [11:0] addr,
                         input logic [31:0] data, input logic [0:0] slot,
                         input logic [7:0] drop);
        n_tests++;
        if ({keyboard_we, keyboard_write_address, keyboard_write_data,
             current_slot, drop_count} !== {we, addr, data, slot, drop}) begin
            n_fail++;
            $display("FAIL %s: got we=%b addr=%0d data=%h slot=%0d drop=%0d, want we=%b addr=%0d data=%h slot=%0d drop=%0d",
                     name, keyboard_we, keyboard_write_address, keyboard_write_data,
                     current_slot, drop_count, we, addr, data, slot, drop);
        end
    endtask

    task automatic step(input logic pr, input logic [7:0] kd, input logic rdy);
        ps2_key_pressed      = pr;
        ps2_key_data         = kd;
        keyboard_write_ready = rdy;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ps2_key_pressed = 1'b0;
        ps2_key_data = 8'h00;
        keyboard_write_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("reset", 0, 64, 0, 0, 0);
        reset = 1'b0;

        // square, release swallowed
        vq.push_back(mk(1, 8'h1C, 1, 0, 64, 0, 0, 0));
        vq.push_back(mk(1, 8'hF0, 1, 0, 64, 0, 0, 0));
        vq.push_back(mk(1, 8'h1C, 1, 0, 64, 0, 0, 0));
        vq.push_back(mk(1, 8'h1E, 1, 1, 64, 32'h08, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 64, 32'h08, 0, 0));
        // left saturates at 0, right moves to 1
        vq.push_back(mk(1, 8'hE0, 1, 0, 64, 32'h08, 0, 0));
        vq.push_back(mk(1, 8'h6B, 1, 0, 64, 32'h08, 0, 0));
        vq.push_back(mk(1, 8'hE0, 1, 0, 64, 32'h08, 0, 0));
        vq.push_back(mk(1, 8'h74, 1, 0, 64, 32'h08, 1, 0));
        vq.push_back(mk(1, 8'h33, 1, 0, 64, 32'h08, 1, 0));
        vq.push_back(mk(1, 8'h3E, 1, 1, 65, 32'h3F, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 65, 32'h3F, 1, 0));
        vq.push_back(mk(1, 8'hE0, 1, 0, 65, 32'h3F, 1, 0));
        vq.push_back(mk(1, 8'h74, 1, 0, 65, 32'h3F, 1, 0));
        // backspace
        vq.push_back(mk(1, 8'h26, 1, 0, 65, 32'h3F, 1, 0));
        vq.push_back(mk(1, 8'h66, 1, 0, 65, 32'h3F, 1, 0));
        vq.push_back(mk(1, 8'h2B, 1, 0, 65, 32'h3F, 1, 0));
        vq.push_back(mk(1, 8'h2E, 1, 1, 65, 32'h25, 1, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 65, 32'h25, 1, 0));
        // back to slot 0, stalled r with drops
        vq.push_back(mk(1, 8'hE0, 0, 0, 65, 32'h25, 1, 0));
        vq.push_back(mk(1, 8'h6B, 0, 0, 65, 32'h25, 0, 0));
        vq.push_back(mk(1, 8'h2D, 0, 1, 67, 32'h01, 0, 0));
        vq.push_back(mk(1, 8'h1C, 0, 1, 67, 32'h01, 0, 1));
        vq.push_back(mk(1, 8'h16, 0, 1, 67, 32'h01, 0, 2));
        vq.push_back(mk(0, 8'h00, 0, 1, 67, 32'h01, 0, 2));
        vq.push_back(mk(0, 8'h00, 1, 0, 67, 32'h01, 0, 2));
        vq.push_back(mk(1, 8'h1C, 1, 0, 67, 32'h01, 0, 2));
        vq.push_back(mk(1, 8'h16, 1, 1, 64, 32'h00, 0, 2));
        vq.push_back(mk(0, 8'h00, 1, 0, 64, 32'h00, 0, 2));
        // k, byte dropped on the ready edge
        vq.push_back(mk(1, 8'h42, 0, 1, 68, 32'h01, 0, 2));
        vq.push_back(mk(1, 8'h1C, 1, 0, 68, 32'h01, 0, 3));
        vq.push_back(mk(1, 8'h16, 1, 0, 68, 32'h01, 0, 3));
        vq.push_back(mk(1, 8'h21, 1, 1, 64, 32'h02, 0, 3));
        vq.push_back(mk(0, 8'h00, 1, 0, 64, 32'h02, 0, 3));
        // release prefix spanning WRITE
        vq.push_back(mk(1, 8'h2D, 0, 1, 67, 32'h01, 0, 3));
        vq.push_back(mk(1, 8'hF0, 0, 1, 67, 32'h01, 0, 3));
        vq.push_back(mk(0, 8'h00, 1, 0, 67, 32'h01, 0, 3));
        vq.push_back(mk(1, 8'h1C, 1, 0, 67, 32'h01, 0, 3));
        vq.push_back(mk(1, 8'h16, 1, 0, 67, 32'h01, 0, 3));
        vq.push_back(mk(1, 8'h34, 1, 1, 64, 32'h06, 0, 3));
        vq.push_back(mk(0, 8'h00, 1, 0, 64, 32'h06, 0, 3));
        // unknown extended code ignored
        vq.push_back(mk(1, 8'hE0, 1, 0, 64, 32'h06, 0, 3));
        vq.push_back(mk(1, 8'h1C, 1, 0, 64, 32'h06, 0, 3));
        vq.push_back(mk(1, 8'h16, 1, 0, 64, 32'h06, 0, 3));
        vq.push_back(mk(1, 8'h66, 1, 0, 64, 32'h06, 0, 3));

        @(negedge clock);
        foreach (vq[i]) begin
            step(vq[i].pr, vq[i].kd, vq[i].rdy);
            check($sformatf("vec%0d", i), vq[i].we, vq[i].addr, vq[i].data,
                  vq[i].slot, vq[i].drop);
        end

        // async reset mid-WRITE
        step(1, 8'hE0, 0);
        step(1, 8'h74, 0);
        step(1, 8'h16, 0);
        step(1, 8'h42, 0);
        check("stall_k", 1, 68, 32'h01, 1, 3);
        #2 reset = 1'b1;
        #1 check("async_rst", 0, 64, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        step(1, 8'h24, 1);
        check("post_rst_letter", 0, 64, 0, 0, 0);
        step(1, 8'h3D, 1);
        check("post_rst_sq", 1, 64, 32'h34, 0, 0);
        step(0, 8'h00, 1);
        check("post_rst_done", 0, 64, 32'h34, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Clocked successor to the chess keyboard front end. Consumes PS/2 scan-code bytes in the system clock domain and assembles square entries (letter + number) and command keys (r, k).
- Issues one write per entry to the memory-mapped board registers using a ready/valid handshake.
- Generalised over number of input slots, address map and data width. Adds break/extended-code parsing, backspace, saturating slot select, and a drop counter.

Parameters:
- ADDR_W, 12, width of keyboard_write_address
- DATA_W, 32, width of keyboard_write_data; must be >= 6
- NUM_SLOTS, 2, number of square-entry slots selectable with the arrow keys; range 1..16
- BASE_ADDR, 64, address of slot 0; slot s writes to BASE_ADDR+s
- CMD_R_ADDR, 67, address written on the r key
- CMD_K_ADDR, 68, address written on the k key

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_key_data  in  8  scan-code byte; valid when ps2_key_pressed is high
- ps2_key_pressed  in  1  one-cycle strobe, synchronous to clock: new byte available
- keyboard_write_ready  in  1  sink accepts the write on this edge
- keyboard_we  out  1  write valid
- keyboard_write_address  out  ADDR_W  target register
- keyboard_write_data  out  DATA_W  write payload
- current_slot  out  $clog2(NUM_SLOTS) (min 1)  selected slot
- drop_count  out  8  saturating count of make codes discarded while busy

Behaviour:
- Reset (asynchronous) values:
  - state=COLLECT; keyboard_we=0; address=BASE_ADDR; data=0; current_slot=0; drop_count=0.
  - Pending letter and number cleared; brk and ext flags cleared.
- A byte is consumed only at a clock edge where ps2_key_pressed=1. All outputs are registered.
- Prefix parsing runs in every state:
  - 0xF0 sets brk.
  - 0xE0 sets ext.
  - When brk is set, the next non-prefix byte is swallowed with no effect, and brk and ext are cleared.
  - When ext is set (and brk is not), the next non-prefix byte is an extended code; ext is cleared afterwards.
- Extended codes in COLLECT:
  - 0x6B (left): current_slot decrements, saturating at 0.
  - 0x74 (right): current_slot increments, saturating at NUM_SLOTS-1.
  - Both clear the pending letter and number.
  - All other extended codes are ignored.
- Plain make codes in COLLECT:
  - Letters A..H = 1C,32,21,23,24,2B,34,33 map to 0..7 and set the pending letter. A repeat press overwrites it.
  - Numbers 1..8 = 16,1E,26,25,2E,36,3D,3E map to 0..7 and set the pending number. A repeat press overwrites it.
  - 0x66 (backspace) clears the pending letter and number.
  - 0x2D (r) and 0x42 (k) clear the pending letter and number, then go to WRITE:
    - r writes address CMD_R_ADDR, data 1.
    - k writes address CMD_K_ADDR, data 1.
  - Other codes are ignored.
- Square completion:
  - Occurs on the edge where the pending letter and number become both valid; entry order is free.
  - Go to WRITE with address BASE_ADDR+current_slot.
  - Data is zero-extended {number[2:0], letter[2:0]} in bits [5:0].
  - Pending letter and number are cleared.
- Latency: completing strobe at edge N → keyboard_we=1 after edge N.
- WRITE state:
  - keyboard_we=1. Address and data are held stable.
  - At the first edge with keyboard_write_ready=1: keyboard_we=0, return to COLLECT. Address and data hold their last values.
  - Non-prefix, non-break bytes arriving in WRITE are discarded and increment drop_count (saturating at 255).
  - This includes a byte arriving on the same edge as ready.
  - Prefix tracking continues, so a release sequence spanning WRITE is still swallowed correctly.
- Slot range: current_slot never exceeds NUM_SLOTS-1.
  - NUM_SLOTS=1: arrows have no slot effect but still clear pending.
- Reset asserted mid-WRITE: keyboard_we drops immediately (asynchronously); the pending transfer is lost.

Test Plan:
- Strobes 1C, F0, 1C, 1E with ready=1 → exactly one write: we high the cycle after the 1E strobe, addr 64, data 0x08 (number 1, letter 0). The release byte 1C produces no effect.
- Strobes E0,74 then 33,3E → current_slot=1, write addr 65, data 0x3F. A further E0,74 leaves slot at 1.
- Strobes 26, 66, 2B, 2E → backspace clears number 2; write data 0x25 (number 4, letter 5).
- ready held 0, strobe 2D → we=1, addr 67, data 1. While stalled, strobes 1C, 16 → drop_count=2 and no new write. Raise ready → we falls after one edge; state returns to COLLECT.
- Strobe 42 → addr 68, data 1. In the same cycle as ready=1, strobe 1C → dropped, drop_count increments.
- Assert reset during WRITE → we=0 asynchronously; after release, slot=0, drop_count=0, pending empty, and the next full square writes normally.
